// File: rtl/arb_client.sv
// arb_client: requester-side agent for one req/ack pair of a four-way
// round-robin arbiter. Jobs from a local producer are queued in a small
// circular FIFO. The head job is served with a four-phase handshake:
// raise req, wait for ack, run the burst, drop req, wait for ack low.
// A request that waits too long is withdrawn and retried later. If the
// grant is lost mid-burst, the job is retried from its full length.
module arb_client #(
    parameter int LEN_W   = 4,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   job_valid,
    input  logic [LEN_W-1:0]       job_len,
    output logic                   job_ready,
    output logic [$clog2(DEPTH):0] pending,
    output logic                   req,
    input  logic                   ack,
    output logic                   xfer_active,
    output logic                   xfer_last,
    output logic                   done,
    output logic                   timeout_err,
    output logic                   abort_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [7:0]       WAIT_LIMIT = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2,
        ST_REL  = 2'd3
    } state_t;

    state_t           state_r, state_s;
    logic [7:0]       wait_r, wait_s;
    logic [LEN_W-1:0] beat_r, beat_s;
    logic [LEN_W-1:0] fifo_mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0] pending_r;
    logic             push_s, pop_s, done_s, timeout_s, abort_s;
    logic             req_r, xfer_active_r, xfer_last_r;
    logic             done_r, timeout_err_r, abort_err_r;

    // The FIFO accepts a job only while it has a free slot. A pop on the
    // same edge does not free a slot for the incoming job.
    assign job_ready = (pending_r != FULL_COUNT);
    assign push_s    = job_valid && job_ready;

    // Handshake sequencing, wait and beat counters, and event strobes
    always_comb begin
        state_s   = state_r;
        wait_s    = wait_r;
        beat_s    = beat_r;
        pop_s     = 1'b0;
        done_s    = 1'b0;
        timeout_s = 1'b0;
        abort_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                wait_s = 8'd0;
                if (pending_r != {CNT_W{1'b0}}) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (ack) begin
                    state_s = ST_XFER;
                    beat_s  = fifo_mem_r[rd_ptr_r];
                end else if (wait_r == WAIT_LIMIT) begin
                    timeout_s = 1'b1;
                    state_s   = ST_REL;
                end else if (wait_r != 8'hFF) begin
                    wait_s = wait_r + 8'd1;
                end else begin
                    wait_s = wait_r;
                end
            end
            ST_XFER: begin
                // Completion of the final beat has priority over grant loss.
                if (beat_r == {LEN_W{1'b0}}) begin
                    pop_s   = 1'b1;
                    done_s  = 1'b1;
                    state_s = ST_REL;
                end else if (!ack) begin
                    abort_s = 1'b1;
                    state_s = ST_REL;
                end else begin
                    beat_s = beat_r - LEN_W'(1);
                end
            end
            ST_REL: begin
                if (!ack) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_REL;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            wait_r  <= 8'd0;
            beat_r  <= {LEN_W{1'b0}};
        end else begin
            state_r <= state_s;
            wait_r  <= wait_s;
            beat_r  <= beat_s;
        end
    end

    // Job storage: write at the tail on an accepted push
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mem_r[i] <= {LEN_W{1'b0}};
            end
        end else if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= job_len;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r  <= {PTR_W{1'b0}};
            rd_ptr_r  <= {PTR_W{1'b0}};
            pending_r <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   pending_r <= pending_r + CNT_W'(1);
                2'b01:   pending_r <= pending_r - CNT_W'(1);
                default: pending_r <= pending_r;
            endcase
        end
    end

    // Registered handshake outputs and single-cycle event pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_r         <= 1'b0;
            xfer_active_r <= 1'b0;
            xfer_last_r   <= 1'b0;
            done_r        <= 1'b0;
            timeout_err_r <= 1'b0;
            abort_err_r   <= 1'b0;
        end else begin
            req_r         <= (state_s == ST_REQ) || (state_s == ST_XFER);
            xfer_active_r <= (state_s == ST_XFER);
            xfer_last_r   <= (state_s == ST_XFER) && (beat_s == {LEN_W{1'b0}});
            done_r        <= done_s;
            timeout_err_r <= timeout_s;
            abort_err_r   <= abort_s;
        end
    end

    assign pending     = pending_r;
    assign req         = req_r;
    assign xfer_active = xfer_active_r;
    assign xfer_last   = xfer_last_r;
    assign done        = done_r;
    assign timeout_err = timeout_err_r;
    assign abort_err   = abort_err_r;

endmodule

// File: tb/tb_arb_client.sv
// Self-checking bench for arb_client: directed scenarios plus a scoreboard
// of expected burst lengths, which is checked on every done pulse.
module tb_arb_client;

    logic       clk;
    logic       rst;
    logic       job_valid;
    logic [3:0] job_len;
    logic       job_ready;
    logic [2:0] pending;
    logic       req;
    logic       ack;
    logic       xfer_active;
    logic       xfer_last;
    logic       done;
    logic       timeout_err;
    logic       abort_err;

    int checks;
    int errors;
    int sb[$];
    int beat_cnt;
    int done_seen;
    int arb_mode;      // 0: ack low, 1: ack follows req, 2: manual
    int arb_lat;       // 0: ack one edge after req, 1: two edges
    logic ack_manual;
    logic req_prev;
    int n;
    int r;

    arb_client #(.LEN_W(4), .DEPTH(4), .TIMEOUT(15)) dut (
        .clk         (clk),
        .rst         (rst),
        .job_valid   (job_valid),
        .job_len     (job_len),
        .job_ready   (job_ready),
        .pending     (pending),
        .req         (req),
        .ack         (ack),
        .xfer_active (xfer_active),
        .xfer_last   (xfer_last),
        .done        (done),
        .timeout_err (timeout_err),
        .abort_err   (abort_err)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic sig_sel(input int sel);
        case (sel)
            0:       return done;
            1:       return req;
            2:       return xfer_active;
            3:       return xfer_last;
            default: return 1'b0;
        endcase
    endfunction

    // Wait (bounded) until the selected output is high at a falling edge
    task automatic wait_for(input int sel, input string tag);
        int   k;
        logic hit;
        k   = 0;
        hit = sig_sel(sel);
        while (!hit && k < 60) begin
            tick();
            k++;
            hit = sig_sel(sel);
        end
        check_value(tag, 32'(hit), 32'd1);
    endtask

    // Wait (bounded) until every queued burst is done, then let REL/IDLE settle
    task automatic wait_drain(input string tag);
        int k;
        k = 0;
        while (!(sb.size() == 0 && pending == 3'd0) && k < 400) begin
            tick();
            k++;
        end
        check_value(tag, 32'(sb.size()), 32'd0);
        repeat (4) tick();
    endtask

    // Arbiter model: updates ack just after each falling edge
    initial begin
        ack      = 1'b0;
        req_prev = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            case (arb_mode)
                1:       ack = (arb_lat == 0) ? req : req_prev;
                2:       ack = ack_manual;
                default: ack = 1'b0;
            endcase
            req_prev = req;
        end
    end

    // Burst monitor: counts beats and pops the scoreboard on each done
    initial begin
        beat_cnt  = 0;
        done_seen = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                beat_cnt = 0;
            end else begin
                if (xfer_active) beat_cnt++;
                if (xfer_last) check_value("last_needs_active", 32'(xfer_active), 32'd1);
                if (abort_err) beat_cnt = 0;
                if (done) begin
                    done_seen++;
                    if (sb.size() == 0) begin
                        check_value("sb_underflow", 32'd1, 32'd0);
                    end else begin
                        check_value("burst_beats", 32'(beat_cnt), 32'(sb.pop_front()));
                    end
                    beat_cnt = 0;
                end
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed scenarios
    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        job_valid  = 1'b0;
        job_len    = 4'd0;
        arb_mode   = 0;
        arb_lat    = 0;
        ack_manual = 1'b0;
        repeat (2) tick();

        // Reset state
        check_value("rst_req", 32'(req), 32'd0);
        check_value("rst_active", 32'(xfer_active), 32'd0);
        check_value("rst_last", 32'(xfer_last), 32'd0);
        check_value("rst_done", 32'(done), 32'd0);
        check_value("rst_tmo", 32'(timeout_err), 32'd0);
        check_value("rst_abort", 32'(abort_err), 32'd0);
        check_value("rst_pending", 32'(pending), 32'd0);
        check_value("rst_ready", 32'(job_ready), 32'd1);
        rst = 1'b0;
        repeat (2) tick();

        // Single job, immediate grant
        arb_mode  = 1;
        arb_lat   = 0;
        job_valid = 1'b1;
        job_len   = 4'd3;
        sb.push_back(4);
        tick();
        job_valid = 1'b0;
        check_value("t1_pending1", 32'(pending), 32'd1);
        check_value("t1_req_lat0", 32'(req), 32'd0);
        tick();
        check_value("t1_req_lat1", 32'(req), 32'd1);
        tick();
        check_value("t1_grant_lat", 32'(xfer_active), 32'd1);
        wait_for(0, "t1_done_seen");
        check_value("t1_pending0", 32'(pending), 32'd0);
        check_value("t1_req_rel", 32'(req), 32'd0);
        tick();
        check_value("t1_done_pulse", 32'(done), 32'd0);
        repeat (4) tick();

        // FIFO full: five pushes with ack held low
        arb_mode = 0;
        for (int i = 0; i < 5; i++) begin
            job_valid = 1'b1;
            job_len   = 4'(i + 1);
            check_value("t2_ready", 32'(job_ready), (i < 4) ? 32'd1 : 32'd0);
            if (i < 4) sb.push_back(i + 2);
            tick();
        end
        job_valid = 1'b0;
        check_value("t2_pending4", 32'(pending), 32'd4);
        check_value("t2_full", 32'(job_ready), 32'd0);
        arb_mode = 1;
        wait_drain("t2_drain");

        // Timeout with ack never asserted
        arb_mode  = 0;
        job_valid = 1'b1;
        job_len   = 4'd2;
        sb.push_back(3);
        tick();
        job_valid = 1'b0;
        wait_for(1, "t3_req_up");
        n = 0;
        while (req && n < 40) begin
            tick();
            n++;
        end
        check_value("t3_req_cycles", 32'(n), 32'd15);
        check_value("t3_tmo_pulse", 32'(timeout_err), 32'd1);
        check_value("t3_pending", 32'(pending), 32'd1);
        tick();
        check_value("t3_gap_req", 32'(req), 32'd0);
        check_value("t3_tmo_once", 32'(timeout_err), 32'd0);
        tick();
        check_value("t3_rereq", 32'(req), 32'd1);
        arb_mode = 1;
        wait_drain("t3_drain");

        // Grant loss during beat 3 of an 8-beat burst
        arb_mode   = 2;
        ack_manual = 1'b0;
        job_valid  = 1'b1;
        job_len    = 4'd7;
        sb.push_back(8);
        tick();
        job_valid = 1'b0;
        wait_for(1, "t4_req_up");
        ack_manual = 1'b1;
        wait_for(2, "t4_beat1");
        tick();
        tick();
        check_value("t4_beat3", 32'(xfer_active), 32'd1);
        ack_manual = 1'b0;
        tick();
        check_value("t4_abort", 32'(abort_err), 32'd1);
        check_value("t4_active_off", 32'(xfer_active), 32'd0);
        check_value("t4_no_done", 32'(done), 32'd0);
        check_value("t4_pending", 32'(pending), 32'd1);
        arb_mode = 1;
        arb_lat  = 0;
        wait_drain("t4_drain");

        // Queue drain with 2-cycle grant latency and a push on the pop edge
        arb_lat   = 1;
        job_valid = 1'b1;
        job_len   = 4'd0;
        sb.push_back(1);
        tick();
        job_len = 4'd15;
        sb.push_back(16);
        tick();
        job_valid = 1'b0;
        wait_for(3, "t5_first_last");
        check_value("t5_pending_pre", 32'(pending), 32'd2);
        check_value("t5_ready", 32'(job_ready), 32'd1);
        job_valid = 1'b1;
        job_len   = 4'd2;
        sb.push_back(3);
        tick();
        job_valid = 1'b0;
        check_value("t5_done", 32'(done), 32'd1);
        check_value("t5_pending_same", 32'(pending), 32'd2);
        wait_drain("t5_drain");
        check_value("t5_done_total", 32'(done_seen), 32'd10);

        // Reset in the middle of a burst
        arb_lat   = 0;
        job_valid = 1'b1;
        job_len   = 4'd15;
        sb.push_back(16);
        tick();
        job_valid = 1'b0;
        wait_for(2, "t6_active");
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        check_value("t6_req", 32'(req), 32'd0);
        check_value("t6_active", 32'(xfer_active), 32'd0);
        check_value("t6_last", 32'(xfer_last), 32'd0);
        check_value("t6_pulses", 32'({done, timeout_err, abort_err}), 32'd0);
        check_value("t6_pending", 32'(pending), 32'd0);
        sb.delete();
        tick();
        rst = 1'b0;
        r = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (req) r++;
        end
        check_value("t6_idle_after", 32'(r), 32'd0);
        job_valid = 1'b1;
        job_len   = 4'd1;
        sb.push_back(2);
        tick();
        job_valid = 1'b0;
        wait_drain("t6_drain");
        check_value("final_done_total", 32'(done_seen), 32'd11);
        check_value("final_pending", 32'(pending), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
